exec_control_decoder: RTL
=========================

Name: exec_control_decoder

Overview:
- Control-side counterpart of the FETCH/EXEC1/EXEC2 phase sequencer in the CPU datapath.
- Consumes the one-hot phase strobes and latches the instruction word during FETCH.
- Decodes the opcode and returns E2 to the sequencer, requesting a second execute cycle for multi-cycle instructions.
- Owns the program counter, instruction register, zero flag and halt state, and drives the datapath control strobes for each phase.

Parameters:
- PCW, 8, program counter width; jump targets are IR[PCW-1:0] with PCW<=8.
- IW, 16, instruction width; fixed encoding below requires IW=16.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous active-high reset.
- FETCH  in  1  fetch phase strobe from sequencer.
- EXEC1  in  1  first execute phase strobe.
- EXEC2  in  1  second execute phase strobe.
- INSTR  in  IW  instruction word from memory; valid while FETCH=1.
- ALU_Z  in  1  ALU zero result; valid during EXEC1 of ADD/SUB.
- E2  out  1  request EXEC2; combinational from IR, gated by EXEC1.
- PC  out  PCW  program counter, used as fetch address.
- IR  out  IW  instruction register.
- RD_SEL  out  2  destination register, IR[11:10].
- RA_SEL  out  2  source A, IR[9:8].
- RB_SEL  out  2  source B, IR[7:6].
- IMM  out  8  immediate, IR[7:0].
- ALU_OP  out  2  00 ADD, 01 SUB, 10 MUL, 11 PASS-B.
- IMM_SEL  out  1  ALU B operand is IMM.
- REG_WE  out  1  register file write enable.
- MEM_RE  out  1  data memory read.
- MEM_WE  out  1  data memory write.
- HALTED  out  1  sticky halt indicator.
- ILLEGAL  out  1  one-cycle pulse on undefined opcode.
- FAULT  out  1  sticky: more than one phase strobe high in the same cycle.

Behaviour:
- Reset (RST=1 at an edge): PC=0, IR=0 (NOP), Z=0, HALTED=0, ILLEGAL=0, FAULT=0. Reset wins over every other event in that cycle, mid-instruction included. All decode outputs are then 0 because IR=NOP.
- FETCH edge (FETCH=1, HALTED=0):
  - IR<=INSTR.
  - PC<=PC+1, wrapping 2^PCW-1 -> 0.
- HALTED=1:
  - FETCH edges leave IR and PC unchanged.
  - All strobes (REG_WE, MEM_RE, MEM_WE, E2) are forced to 0.
  - Only RST clears HALTED.
- Opcode IR[15:12], with per-phase strobe and E2 behaviour:
  - 0x0 NOP: nothing asserted.
  - 0x1 ADD / 0x2 SUB:
    - EXEC1: ALU_OP=00/01, REG_WE=1.
    - EXEC1 edge: Z<=ALU_Z.
    - E2=0.
  - 0x3 LDI:
    - EXEC1: ALU_OP=11, IMM_SEL=1, REG_WE=1.
    - E2=0.
  - 0x4 LD:
    - EXEC1: MEM_RE=1, E2=1.
    - EXEC2: MEM_RE=1, REG_WE=1.
  - 0x5 ST:
    - EXEC1: MEM_WE=1.
    - E2=0.
  - 0x6 JMP:
    - EXEC1 edge: PC<=IR[PCW-1:0].
    - E2=0.
  - 0x7 JZ:
    - EXEC1 edge: if Z=1, PC<=IR[PCW-1:0]; otherwise PC unchanged.
    - E2=0.
  - 0x8 MUL:
    - EXEC1: ALU_OP=10, E2=1.
    - EXEC2: ALU_OP=10, REG_WE=1.
  - 0xF HALT: EXEC1 edge: HALTED<=1.
  - 0x9-0xE: treated as NOP. ILLEGAL pulses for exactly one cycle after the EXEC1 edge.
- Strobe gating:
  - E2 = EXEC1 & (opcode is LD or MUL) & ~HALTED.
  - E2 is 0 in every other phase.
  - Strobes are asserted only while their phase input is high; all are combinational from IR and the phase inputs.
- Latency:
  - IR is visible the cycle after FETCH.
  - PC change is visible the cycle after the FETCH/EXEC1 edge.
  - A jump overrides the FETCH increment: jumps occur at EXEC1, after that increment.
- Z is updated only by ADD/SUB; it holds otherwise.
- FAULT:
  - Set when two or more of FETCH/EXEC1/EXEC2 are high at an edge.
  - In that cycle no state is updated except FAULT; all strobes are 0.
- EXEC2 with a single-cycle opcode (sequencer error): no strobes, no state change.

Test Plan:
- RST, then FETCH with INSTR=0x1E40 (ADD R3,R2,R1), then EXEC1 with ALU_Z=1 -> PC=1; IR=0x1E40; EXEC1: ALU_OP=00, REG_WE=1, E2=0; afterwards Z=1.
- FETCH INSTR=0x4900 (LD R2,[R1]) -> EXEC1: E2=1, MEM_RE=1, REG_WE=0; EXEC2: MEM_RE=1, REG_WE=1; E2=0 during EXEC2.
- JZ 0x70A5: with Z=1 -> PC=0xA5 after EXEC1; repeat with Z=0 -> PC=fetch address+1.
- PC at 0xFF, FETCH NOP -> PC=0x00; JMP 0x60FF -> PC=0xFF.
- FETCH 0xF000 (HALT), EXEC1 -> HALTED=1; subsequent FETCH with INSTR=0x1000 leaves PC/IR unchanged, all strobes 0; RST -> HALTED=0, PC=0.
- Opcode 0xA -> ILLEGAL high for exactly one cycle after EXEC1; FETCH=EXEC1=1 at the same edge -> FAULT=1 sticky, PC unchanged; RST mid-LD (during EXEC1) -> IR=0, E2=0 next cycle.

Source files
------------

// File: rtl/exec_control_decoder.sv
// Control-side decoder for the FETCH/EXEC1/EXEC2 sequencer: owns PC, IR, Z and halt state,
// and drives the per-phase datapath strobes combinationally from IR and the phase inputs.
module exec_control_decoder #(
  parameter int PCW = 8,
  parameter int IW  = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           FETCH,
  input  logic           EXEC1,
  input  logic           EXEC2,
  input  logic [IW-1:0]  INSTR,
  input  logic           ALU_Z,
  output logic           E2,
  output logic [PCW-1:0] PC,
  output logic [IW-1:0]  IR,
  output logic [1:0]     RD_SEL,
  output logic [1:0]     RA_SEL,
  output logic [1:0]     RB_SEL,
  output logic [7:0]     IMM,
  output logic [1:0]     ALU_OP,
  output logic           IMM_SEL,
  output logic           REG_WE,
  output logic           MEM_RE,
  output logic           MEM_WE,
  output logic           HALTED,
  output logic           ILLEGAL,
  output logic           FAULT
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_LDI  = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_JMP  = 4'h6,
    OP_JZ   = 4'h7,
    OP_MUL  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  logic [PCW-1:0] pc_r;
  logic [IW-1:0]  ir_r;
  logic           z_r;
  logic           halted_r;
  logic           illegal_r;
  logic           fault_r;

  logic [3:0]     opcode_s;
  logic           multi_phase_s;
  logic           active_s;
  logic [PCW-1:0] jump_target_s;

  // Opcodes 0x9-0xE have no function and are flagged as illegal.
  function automatic logic is_undefined(input logic [3:0] op);
    is_undefined = (op >= 4'h9) && (op <= 4'hE);
  endfunction

  assign opcode_s      = ir_r[15:12];
  assign jump_target_s = ir_r[PCW-1:0];
  assign multi_phase_s = (FETCH & EXEC1) | (FETCH & EXEC2) | (EXEC1 & EXEC2);
  // Strobes are suppressed while halted and in any cycle with overlapping phases.
  assign active_s      = ~halted_r & ~multi_phase_s;

  // Architectural state: PC, IR, zero flag, halt, illegal pulse and sticky fault.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r      <= '0;
      ir_r      <= '0;
      z_r       <= 1'b0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      illegal_r <= 1'b0;
      if (multi_phase_s) begin
        fault_r <= 1'b1;
      end else if (FETCH && !halted_r) begin
        ir_r <= INSTR;
        pc_r <= pc_r + {{(PCW-1){1'b0}}, 1'b1};
      end else if (EXEC1 && !halted_r) begin
        case (opcode_s)
          OP_ADD, OP_SUB: z_r      <= ALU_Z;
          OP_JMP:         pc_r     <= jump_target_s;
          OP_JZ:          pc_r     <= z_r ? jump_target_s : pc_r;
          OP_HALT:        halted_r <= 1'b1;
          default:        illegal_r <= is_undefined(opcode_s);
        endcase
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Per-phase strobe decode.
  always_comb begin
    E2      = 1'b0;
    ALU_OP  = 2'b00;
    IMM_SEL = 1'b0;
    REG_WE  = 1'b0;
    MEM_RE  = 1'b0;
    MEM_WE  = 1'b0;
    if (active_s && EXEC1) begin
      case (opcode_s)
        OP_ADD: begin ALU_OP = 2'b00; REG_WE = 1'b1; end
        OP_SUB: begin ALU_OP = 2'b01; REG_WE = 1'b1; end
        OP_LDI: begin ALU_OP = 2'b11; IMM_SEL = 1'b1; REG_WE = 1'b1; end
        OP_LD:  begin MEM_RE = 1'b1; E2 = 1'b1; end
        OP_ST:  MEM_WE = 1'b1;
        OP_MUL: begin ALU_OP = 2'b10; E2 = 1'b1; end
        default: ALU_OP = 2'b00;
      endcase
    end else if (active_s && EXEC2) begin
      case (opcode_s)
        OP_LD:  begin MEM_RE = 1'b1; REG_WE = 1'b1; end
        OP_MUL: begin ALU_OP = 2'b10; REG_WE = 1'b1; end
        default: ALU_OP = 2'b00;
      endcase
    end else begin
      E2 = 1'b0;
    end
  end

  assign PC      = pc_r;
  assign IR      = ir_r;
  assign RD_SEL  = ir_r[11:10];
  assign RA_SEL  = ir_r[9:8];
  assign RB_SEL  = ir_r[7:6];
  assign IMM     = ir_r[7:0];
  assign HALTED  = halted_r;
  assign ILLEGAL = illegal_r;
  assign FAULT   = fault_r;

endmodule
